dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache with a CPU-side request/done handshake and a memory-side request/ack handshake. It generalises the single-port fill-only cache: configurable address, index and data widths, and real read-miss refill. It adds write-through forwarding, whole-cache flush and saturating hit/miss counters. It sits between the CPU load/store unit and the multi-cycle main memory model.

Parameters:
ADDR_W, 15, word address width
INDEX_W, 12, index bits (2^INDEX_W lines, one word per line); TAG_W = ADDR_W-INDEX_W
DATA_W, 32, word width
CNT_W, 16, hit/miss counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  request valid, sampled only when cpu_ready=1
cpu_we  in  1  1=write, 0=read (qualified by cpu_req)
cpu_addr  in  ADDR_W  word address; tag=[ADDR_W-1:INDEX_W], index=[INDEX_W-1:0]
cpu_wdata  in  DATA_W  write data
flush  in  1  invalidate all lines
cpu_ready  out  1  controller can accept a request
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_done=1
cpu_hit  out  1  completed access hit, valid while cpu_done=1
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, one cycle; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Storage: data array, tag array and valid bit per line. Only the valid bits, FSM state, counters and outputs are reset; data and tag arrays are not.
- Reset (rst=1 at an edge): state=IDLE; all valid=0; hit_count=miss_count=0; cpu_done=0, cpu_hit=0, mem_rd=0, mem_wr=0, cpu_rdata=0. Reset overrides any in-flight access, and that access never completes.
- cpu_ready = (state==IDLE) && !flush && !rst.
- FSM states: IDLE, COMPARE, MEM_READ, MEM_WRITE.
- IDLE:
  - flush=1 clears all valid bits at that edge. Flush has priority over cpu_req.
  - Otherwise, cpu_req=1 latches addr/we/wdata and moves to COMPARE.
- COMPARE (one cycle): hit = valid[index] && tag_array[index]==tag.
  - Read hit: cpu_done=1, cpu_hit=1, cpu_rdata=data[index] next cycle; hit_count++ ; go to IDLE.
  - Read miss: miss_count++ ; mem_rd=1, mem_addr=addr; go to MEM_READ.
  - Write (hit or miss): mem_wr=1, mem_addr=addr, mem_wdata=wdata; hit/miss counted as for reads; go to MEM_WRITE.
- Read-hit latency: request accepted at edge E0; cpu_done high in the cycle after edge E1 (2-edge latency).
- MEM_READ: mem_rd/mem_addr held stable until mem_ack.
  - On the mem_ack edge: data[index]=mem_rdata, tag[index]=tag, valid[index]=1; cpu_done=1, cpu_hit=0, cpu_rdata=mem_rdata; mem_rd=0; go to IDLE.
- MEM_WRITE: held until mem_ack.
  - On the mem_ack edge: if the access was a hit, data[index]=wdata; a miss allocates nothing. cpu_done=1, cpu_hit=latched hit; mem_wr=0; go to IDLE.
- mem_ack outside MEM_READ/MEM_WRITE is ignored. mem_rd and mem_wr are never high together.
- cpu_done is high for exactly one cycle per accepted request. A new request may be accepted in the same cycle cpu_done is high (cpu_ready=1 then).
- Counters saturate at 2^CNT_W-1, with no wrap-around.
- Flush asserted while state≠IDLE is ignored; the requester must hold it until cpu_ready would otherwise be 1.
- Aliasing: same index with a different tag misses; the refill replaces the line.

Test Plan:
- Reset, read 0x1234 (idx 0x234, tag 1), mem_ack after 3 cycles with 0xDEADBEEF -> mem_rd high 3 cycles, mem_addr=0x1234; cpu_done with cpu_hit=0, rdata=0xDEADBEEF; miss_count=1.
- Re-read 0x1234 -> cpu_done 2 edges after accept, cpu_hit=1, rdata=0xDEADBEEF, no mem_rd; hit_count=1.
- Write 0x1234=0x0000CAFE, then read 0x1234 -> mem_wr with mem_wdata=0x0000CAFE; read hits returning 0x0000CAFE. Write 0x5234 (miss) -> mem_wr only; a subsequent read of 0x5234 misses.
- Read 0x2234 after 0x1234 is cached -> miss and refill; a following read of 0x1234 misses again (tag conflict).
- flush pulse together with cpu_req in IDLE -> request not accepted (cpu_ready=0); the next read of 0x2234 misses.
- rst asserted mid MEM_READ -> mem_rd=0 the next cycle, no cpu_done, counters=0; preload miss_count to max via CNT_W=2 -> stays 3.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
// One word per line; 2^INDEX_W lines. Read misses refill the line from memory. Writes are
// always forwarded to memory and update the line only when it already holds the address.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request, accepted when cpu_ready=1
//   flush                    invalidate every line (only acted on in IDLE)
//   cpu_ready                combinational accept indication
//   cpu_done/hit/rdata       one-cycle completion pulse with hit flag and read data
//   mem_rd/wr/addr/wdata     memory request, held until mem_ack
//   mem_ack/mem_rdata        memory completion, read data valid with the ack
//   hit_count/miss_count     saturating access counters
module dm_cache_ctrl #(
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned INDEX_W = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              flush,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W;
   localparam int unsigned LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, COMPARE, MEM_READ, MEM_WRITE} state_t;

   state_t state, state_nx;

   // Line storage; only the valid bits are reset.
   logic [DATA_W-1:0] data_array [LINES];
   logic [TAG_W-1:0]  tag_array  [LINES];
   logic [LINES-1:0]  valid;

   // Request captured at accept time.
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;
   logic              req_hit;

   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   logic               lookup_hit;
   logic               accept;

   logic              done_nx, hit_nx, mem_rd_nx, mem_wr_nx;
   logic [DATA_W-1:0] rdata_nx, mem_wdata_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [CNT_W-1:0]  hit_count_nx, miss_count_nx;
   logic              flush_all, fill, wr_update;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign req_index  = req_addr[INDEX_W-1:0];
   assign req_tag    = req_addr[ADDR_W-1:INDEX_W];
   assign lookup_hit = valid[req_index] && (tag_array[req_index] == req_tag);
   assign cpu_ready  = (state == IDLE) && !flush && !rst;
   assign accept     = (state == IDLE) && !flush && cpu_req;

   // Next-state and next-output logic.
   always_comb begin
      state_nx      = state;
      done_nx       = 1'b0;
      hit_nx        = 1'b0;
      rdata_nx      = cpu_rdata;
      mem_rd_nx     = mem_rd;
      mem_wr_nx     = mem_wr;
      mem_addr_nx   = mem_addr;
      mem_wdata_nx  = mem_wdata;
      hit_count_nx  = hit_count;
      miss_count_nx = miss_count;
      flush_all     = 1'b0;
      fill          = 1'b0;
      wr_update     = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               flush_all = 1'b1;
            end else if (cpu_req) begin
               state_nx = COMPARE;
            end
         end
         COMPARE: begin
            if (lookup_hit) begin
               hit_count_nx = sat_inc(hit_count);
            end else begin
               miss_count_nx = sat_inc(miss_count);
            end
            if (req_we) begin
               mem_wr_nx    = 1'b1;
               mem_addr_nx  = req_addr;
               mem_wdata_nx = req_wdata;
               state_nx     = MEM_WRITE;
            end else if (lookup_hit) begin
               done_nx  = 1'b1;
               hit_nx   = 1'b1;
               rdata_nx = data_array[req_index];
               state_nx = IDLE;
            end else begin
               mem_rd_nx   = 1'b1;
               mem_addr_nx = req_addr;
               state_nx    = MEM_READ;
            end
         end
         MEM_READ: begin
            if (mem_ack) begin
               fill      = 1'b1;
               done_nx   = 1'b1;
               rdata_nx  = mem_rdata;
               mem_rd_nx = 1'b0;
               state_nx  = IDLE;
            end
         end
         MEM_WRITE: begin
            if (mem_ack) begin
               wr_update = req_hit;
               done_nx   = 1'b1;
               hit_nx    = req_hit;
               mem_wr_nx = 1'b0;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, outputs, counters and valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         cpu_done   <= 1'b0;
         cpu_hit    <= 1'b0;
         cpu_rdata  <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state      <= state_nx;
         cpu_done   <= done_nx;
         cpu_hit    <= hit_nx;
         cpu_rdata  <= rdata_nx;
         mem_rd     <= mem_rd_nx;
         mem_wr     <= mem_wr_nx;
         mem_addr   <= mem_addr_nx;
         mem_wdata  <= mem_wdata_nx;
         hit_count  <= hit_count_nx;
         miss_count <= miss_count_nx;
         if (flush_all) begin
            valid <= '0;
         end else if (fill) begin
            valid[req_index] <= 1'b1;
         end
      end
   end

   // Data/tag arrays: refill on read miss, update on write hit; reset blocks a late ack.
   always_ff @(posedge clk) begin
      if (!rst && fill) begin
         data_array[req_index] <= mem_rdata;
         tag_array[req_index]  <= req_tag;
      end else if (!rst && wr_update) begin
         data_array[req_index] <= req_wdata;
      end
   end

   // Request capture; the hit result is kept for the write-completion response.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_addr  <= cpu_addr;
         req_we    <= cpu_we;
         req_wdata <= cpu_wdata;
      end
      if (state == COMPARE) begin
         req_hit <= lookup_hit;
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench for dm_cache_ctrl with a transaction-level cache model.
// The driver advances the model per access and publishes the expected outputs; a negedge
// process compares every DUT output against them each cycle. A few literal checks pin the model.
module tb_dm_cache_ctrl;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned INDEX_W = 12;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              flush;
   logic              cpu_ready;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_hit;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   dm_cache_ctrl #(
      .ADDR_W (ADDR_W),
      .INDEX_W(INDEX_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .flush     (flush),
      .cpu_ready (cpu_ready),
      .cpu_done  (cpu_done),
      .cpu_rdata (cpu_rdata),
      .cpu_hit   (cpu_hit),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Expected outputs published by the driver.
   logic              exp_ready, exp_done, exp_hit, exp_is_read, exp_mem_rd, exp_mem_wr;
   logic [DATA_W-1:0] exp_rdata, exp_wdata;
   logic [ADDR_W-1:0] exp_addr;

   // Cache model: lines keyed by index.
   bit                m_valid [int];
   int                m_tag   [int];
   logic [DATA_W-1:0] m_data  [int];
   int                m_hits;
   int                m_misses;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [ADDR_W-1:0] a);
      return int'(a) % (1 << INDEX_W);
   endfunction

   function automatic int tag_of(input logic [ADDR_W-1:0] a);
      return int'(a) / (1 << INDEX_W);
   endfunction

   function automatic bit model_hit(input logic [ADDR_W-1:0] a);
      int i;
      i = idx_of(a);
      return m_valid.exists(i) && (m_tag[i] == tag_of(a));
   endfunction

   function automatic int sat(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_ready", 64'(cpu_ready), 64'(exp_ready));
         chk("cpu_done", 64'(cpu_done), 64'(exp_done));
         if (exp_done) begin
            chk("cpu_hit", 64'(cpu_hit), 64'(exp_hit));
            if (exp_is_read) chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
         end
         chk("mem_rd", 64'(mem_rd), 64'(exp_mem_rd));
         chk("mem_wr", 64'(mem_wr), 64'(exp_mem_wr));
         if (exp_mem_rd || exp_mem_wr) chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
         if (exp_mem_wr) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
         chk("hit_count", 64'(hit_count), 64'(m_hits));
         chk("miss_count", 64'(miss_count), 64'(m_misses));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         exp_done = 1'b0;
      end
   endtask

   // One CPU access; returns 1 time unit into the cpu_done cycle so a new request can follow.
   task automatic access(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input int delay, input logic [DATA_W-1:0] rd);
      bit h;
      int i;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(posedge clk);
      #1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      exp_done  = 1'b0;
      exp_ready = 1'b0;
      h = model_hit(addr);
      i = idx_of(addr);
      @(posedge clk);
      #1;
      if (h) m_hits = sat(m_hits);
      else   m_misses = sat(m_misses);
      if (!we && h) begin
         exp_done    = 1'b1;
         exp_hit     = 1'b1;
         exp_is_read = 1'b1;
         exp_rdata   = m_data[i];
         exp_ready   = 1'b1;
      end else begin
         exp_addr = addr;
         if (we) begin
            exp_mem_wr = 1'b1;
            exp_wdata  = wd;
         end else begin
            exp_mem_rd = 1'b1;
         end
         for (int k = 1; k <= delay; k++) begin
            if (k == delay) begin
               mem_ack   = 1'b1;
               mem_rdata = rd;
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_0000 | DATA_W'(k);
         end
         exp_mem_rd  = 1'b0;
         exp_mem_wr  = 1'b0;
         exp_done    = 1'b1;
         exp_ready   = 1'b1;
         exp_is_read = !we;
         if (we) begin
            exp_hit = h;
            if (h) m_data[i] = wd;
         end else begin
            exp_hit    = 1'b0;
            exp_rdata  = rd;
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(addr);
            m_data[i]  = rd;
         end
      end
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      exp_ready = 1'b0; exp_done = 1'b0; exp_hit = 1'b0; exp_is_read = 1'b0;
      exp_mem_rd = 1'b0; exp_mem_wr = 1'b0; exp_rdata = '0; exp_wdata = '0; exp_addr = '0;
      m_hits = 0; m_misses = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ready = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("lit_reset_hits", 64'(hit_count), 64'(0));
      chk("lit_reset_done", 64'(cpu_done), 64'(0));

      // First read misses and refills.
      access(1'b0, 15'h1234, '0, 3, 32'hDEADBEEF);
      @(negedge clk);
      chk("lit_miss_rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
      chk("lit_miss_hit", 64'(cpu_hit), 64'(0));
      chk("lit_miss_count", 64'(miss_count), 64'(1));

      // Re-read hits, issued in the done cycle of the previous access.
      access(1'b0, 15'h1234, '0, 1, '0);
      @(negedge clk);
      chk("lit_hit_flag", 64'(cpu_hit), 64'(1));
      chk("lit_hit_count", 64'(hit_count), 64'(1));

      // Write hit updates the line.
      access(1'b1, 15'h1234, 32'h0000CAFE, 2, '0);
      access(1'b0, 15'h1234, '0, 1, '0);
      @(negedge clk);
      chk("lit_write_hit_rdata", 64'(cpu_rdata), 64'(32'h0000CAFE));

      // Write miss does not allocate.
      access(1'b1, 15'h5234, 32'h1111_2222, 1, '0);
      access(1'b0, 15'h5234, '0, 2, 32'h5555_5555);

      // Spurious ack outside a memory access is ignored.
      idle(1);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      idle(1);
      mem_ack = 1'b0;

      // Tag conflict on the same index.
      access(1'b0, 15'h2234, '0, 1, 32'h2222_2222);
      access(1'b0, 15'h1234, '0, 4, 32'h1234_1234);
      @(negedge clk);
      chk("lit_miss_saturated", 64'(miss_count), 64'(3));
      access(1'b0, 15'h2234, '0, 2, 32'h2222_AAAA);
      access(1'b0, 15'h2234, '0, 1, '0);
      idle(1);

      // Flush with a simultaneous request: request refused, lines invalidated.
      flush = 1'b1; cpu_req = 1'b1; cpu_addr = 15'h2234;
      exp_ready = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0; cpu_req = 1'b0;
      exp_ready = 1'b1;
      m_valid.delete();
      idle(1);
      access(1'b0, 15'h2234, '0, 1, 32'h3333_3333);
      idle(1);

      // Reset in the middle of a refill.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0AAA;
      @(posedge clk); #1;
      cpu_req = 1'b0; exp_done = 1'b0; exp_ready = 1'b0;
      @(posedge clk); #1;
      m_misses = sat(m_misses);
      exp_mem_rd = 1'b1; exp_addr = 15'h0AAA;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_mem_rd = 1'b0; exp_ready = 1'b1;
      m_hits = 0; m_misses = 0;
      m_valid.delete();
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      idle(1);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("lit_rst_hits", 64'(hit_count), 64'(0));
      chk("lit_rst_misses", 64'(miss_count), 64'(0));
      chk("lit_rst_mem_rd", 64'(mem_rd), 64'(0));

      // Push the miss counter past its maximum.
      access(1'b0, 15'h0AAA, '0, 1, 32'hA0A0_A0A0);
      access(1'b0, 15'h1001, '0, 2, 32'hB1B1_B1B1);
      access(1'b1, 15'h2002, 32'h0000_0002, 1, '0);
      access(1'b0, 15'h3003, '0, 1, 32'hC3C3_C3C3);
      access(1'b0, 15'h0AAA, '0, 1, '0);
      @(negedge clk);
      chk("lit_final_misses", 64'(miss_count), 64'(3));
      chk("lit_final_hits", 64'(hit_count), 64'(1));
      chk("lit_final_rdata", 64'(cpu_rdata), 64'(32'hA0A0_A0A0));
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
